// File: rtl/nf10_axis_sf_egress_fifo.sv
// Store-and-forward AXI4-Stream egress buffer placed in front of a 10G port.
// Holds beats until a whole packet is stored, then releases it back-to-back.
// Falls back to cut-through when the FIFO fills without a tlast.
// Ports:
//   aclk, areset                 clock, async active-high reset
//   s_axis_*                     beats from the output queue (slave)
//   m_axis_*                     beats towards the port (master)
//   pkt_count                    complete packets currently stored
//   counter                      packets emitted, wraps at 256
//   activity                     one-cycle pulse per emitted tlast beat
module nf10_axis_sf_egress_fifo #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_DEPTH_LOG2         = 6
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    output logic [C_DEPTH_LOG2:0]             pkt_count,
    output logic [7:0]                        counter,
    output logic                              activity
);

    localparam int DW    = C_S_AXIS_DATA_WIDTH;
    localparam int SW    = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW    = C_S_AXIS_TUSER_WIDTH;
    localparam int EW    = 1 + UW + SW + DW;
    localparam int PW    = C_DEPTH_LOG2;
    localparam int CW    = C_DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << C_DEPTH_LOG2;

    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [7:0]    CTR_ONE = 8'd1;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] rd_word;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] pkt_q, pkt_d;
    logic          rdy_q, rdy_d;
    logic [7:0]    ctr_q, ctr_d;
    logic          act_q;
    state_t        state_q, state_d;

    logic push, pop;
    logic push_last, pop_last;

    assign push      = s_axis_tvalid & rdy_q;
    assign pop       = m_axis_tvalid & m_axis_tready;
    assign push_last = push & s_axis_tlast;
    assign pop_last  = pop & m_axis_tlast;

    // Asynchronous read: the head entry is presented directly, so it holds
    // still under backpressure because rd_ptr only moves on a pop.
    assign rd_word = mem_q[rd_ptr_q];

    assign m_axis_tlast  = rd_word[EW-1];
    assign m_axis_tuser  = rd_word[DW+SW +: UW];
    assign m_axis_tstrb  = rd_word[DW +: SW];
    assign m_axis_tdata  = rd_word[0 +: DW];
    assign m_axis_tvalid = (state_q == SEND) && (count_q != '0);

    // Ready is a flop mirroring (count != depth): it stays low until the
    // first clock after reset and never depends on m_axis_tready in-cycle.
    assign s_axis_tready = rdy_q;
    assign pkt_count     = pkt_q;
    assign counter       = ctr_q;
    assign activity      = act_q;

    always_ff @(posedge aclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {s_axis_tlast, s_axis_tuser,
                                s_axis_tstrb, s_axis_tdata};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pkt_d    = pkt_q;
        ctr_d    = ctr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
        if (push_last && !pop_last) begin
            pkt_d = pkt_q + CNT_ONE;
        end else if (pop_last && !push_last) begin
            pkt_d = pkt_q - CNT_ONE;
        end
        if (pop_last) begin
            ctr_d = ctr_q + CTR_ONE;
        end
        rdy_d = (count_d != FULL);
    end

    // Next-state uses the updated counts so a tlast pushed this cycle
    // starts transmission on the very next cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if ((pkt_d != '0) || (count_d == FULL)) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (pop_last && (pkt_d == '0) && (count_d != FULL)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pkt_q    <= '0;
            rdy_q    <= 1'b0;
            ctr_q    <= '0;
            act_q    <= 1'b0;
            state_q  <= IDLE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            pkt_q    <= pkt_d;
            rdy_q    <= rdy_d;
            ctr_q    <= ctr_d;
            act_q    <= pop_last;
            state_q  <= state_d;
        end
    end

endmodule

// File: doc/nf10_axis_sf_egress_fifo.md
# nf10_axis_sf_egress_fifo

Store-and-forward AXI4-Stream packet buffer that sits directly upstream of each 10G port recorder/MAC, fed by one `m_axis_N` port of the BRAM output queues. It accepts beats from the output queue, holds them until a complete packet (tlast) is stored, then releases the whole packet back-to-back, so the downstream port never sees mid-packet bubbles. Full-FIFO cut-through prevents deadlock on oversize packets. An 8-bit egress packet counter and an activity pulse are provided for monitoring.

## Interface
- C_S_AXIS_DATA_WIDTH, 256, tdata width; tstrb is width/8
- C_S_AXIS_TUSER_WIDTH, 128, tuser width, stored per beat
- C_DEPTH_LOG2, 6, FIFO depth = 2^C_DEPTH_LOG2 beats (64)
- aclk  in  1  sole clock, all logic rising-edge
- areset  in  1  asynchronous, active-high reset
- s_axis_tdata/tstrb/tuser/tvalid/tlast  in  256/32/128/1/1  slave stream from output queue
- s_axis_tready  out  1  slave ready
- m_axis_tdata/tstrb/tuser/tvalid/tlast  out  256/32/128/1/1  master stream to port
- m_axis_tready  in  1  master ready
- pkt_count  out  C_DEPTH_LOG2+1  complete packets currently stored
- counter  out  8  packets emitted (tlast beats accepted downstream), wraps 255->0
- activity  out  1  one-cycle pulse per emitted tlast beat

## Operation
- Storage: circular RAM of 2^C_DEPTH_LOG2 entries {tlast, tuser, tstrb, tdata}; wr_ptr, rd_ptr C_DEPTH_LOG2 bits, wrap modulo depth; word_count C_DEPTH_LOG2+1 bits.
- Push = s_axis_tvalid & s_axis_tready; pop = m_axis_tvalid & m_axis_tready.
- s_axis_tready = (word_count != depth), combinational from registered count.
- pkt_count: +1 on push with tlast, -1 on pop with tlast, unchanged when both in same cycle.
- Output FSM, states IDLE / SEND:
  - IDLE: m_axis_tvalid = 0. Go SEND when pkt_count != 0 or word_count == depth (cut-through).
  - SEND: m_axis_tvalid = (word_count != 0); outputs show entry at rd_ptr. On pop with tlast: return to IDLE if pkt_count after update is 0 and not full, else stay SEND.
- Once SEND entered, the packet is forwarded to its tlast even if cut-through (source keeps writing behind the read pointer); tvalid may drop only in cut-through when FIFO runs empty.
- m_axis_* data/strb/user/last are don't-care when tvalid = 0 but must not change while tvalid=1 & tready=0.
- counter increments on every pop with tlast; activity = registered (pop & tlast).

## Timing
- Reset (async assert, sync release): wr_ptr = rd_ptr = 0, word_count = 0, pkt_count = 0, state IDLE, m_axis_tvalid = 0, s_axis_tready = 1 after first clock (0 while areset high), counter = 0, activity = 0. RAM contents not reset.
- Latency: tlast beat pushed in cycle N -> pkt_count updated and state SEND at edge ending N -> m_axis_tvalid = 1 in cycle N+1 with first beat of that packet.
- Throughput: one beat in and one beat out per cycle simultaneously; back-to-back packets with no idle cycle between them while pkt_count > 1.
- Full: push refused while word_count == depth; simultaneous pop frees a slot visible next cycle (tready not combinationally dependent on m_axis_tready).
- Empty: pop impossible; tvalid = 0.
- Reset mid-packet: all stored data discarded; partial packets lost, no tlast emitted.

## Test plan
- Single 4-beat packet, m_axis_tready=1: tvalid rises the cycle after input tlast, 4 consecutive beats with identical tdata/tstrb/tuser, counter 0->1, activity one pulse.
- Three 2-beat packets back-to-back, tready=1: output 6 contiguous valid beats, pkt_count peaks at >=1, counter=3.
- Fill with 64 non-tlast beats, tready=0: s_axis_tready=0 after 64th beat; raise tready: cut-through drains, 65th beat with tlast accepted, counter=1.
- Random tready (50%) with 100 random-length (1-16 beat) packets: output stream bit-exact to input, no beat dropped/duplicated, counter=100 mod 256.
- Push tlast and pop tlast in same cycle with pkt_count=1: pkt_count stays 1.
- Assert areset mid-packet with 10 beats stored: next cycle m_axis_tvalid=0, pkt_count=0, counter=0; a new 1-beat packet then passes correctly.
